// File: rtl/trivium_stream_decrypt.sv
// Byte-wide Trivium stream decryptor: 1152-round warm-up, then 8 keystream bits per ciphertext byte.
// Optional TRIVIUM_DEC_PREFETCH_EN keeps the next keystream byte ready for single-cycle turnaround.
module trivium_stream_decrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] key,
    input  logic [79:0] iv,
    output logic        busy,
    output logic        init_done,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);
    typedef enum logic [2:0] {IDLE, INIT, GEN, READY, OUT} state_t;

    state_t       r_state;
    logic [287:0] r_s;
    logic [10:0]  r_rcnt;
    logic [2:0]   r_bcnt;
    logic [7:0]   r_ks;
    logic         r_busy;
    logic         r_init_done;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [7:0]   r_out_data;
`ifndef TRIVIUM_DEC_PREFETCH_EN
    logic [7:0]   r_din;
`endif

    logic         w_t1, w_t2, w_t3, w_z;
    logic         w_n1, w_n2, w_n3;
    logic [287:0] w_s_next;
    logic [287:0] w_s_load;

    // r_s[k-1] holds state bit s_k
    always_comb begin
        w_t1     = r_s[65]  ^ r_s[92];
        w_t2     = r_s[161] ^ r_s[176];
        w_t3     = r_s[242] ^ r_s[287];
        w_z      = w_t1 ^ w_t2 ^ w_t3;
        w_n1     = w_t1 ^ (r_s[90]  & r_s[91])  ^ r_s[170];
        w_n2     = w_t2 ^ (r_s[174] & r_s[175]) ^ r_s[263];
        w_n3     = w_t3 ^ (r_s[285] & r_s[286]) ^ r_s[68];
        w_s_next = {r_s[286:177], w_n2, r_s[175:93], w_n1, r_s[91:0], w_n3};
        w_s_load = {3'b111, 112'd0, iv, 13'd0, key};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_rcnt      <= '0;
            r_bcnt      <= '0;
            r_ks        <= '0;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifndef TRIVIUM_DEC_PREFETCH_EN
            r_din       <= '0;
`endif
        end else if (start) begin
            r_state     <= INIT;
            r_s         <= w_s_load;
            r_rcnt      <= '0;
            r_bcnt      <= '0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_s    <= w_s_next;
                    r_rcnt <= r_rcnt + 11'd1;
                    if (r_rcnt == 11'd1151) begin
`ifdef TRIVIUM_DEC_PREFETCH_EN
                        r_state <= GEN;
                        r_bcnt  <= '0;
`else
                        r_state     <= READY;
                        r_busy      <= 1'b0;
                        r_init_done <= 1'b1;
                        r_in_ready  <= 1'b1;
`endif
                    end
                end
                READY: begin
`ifdef TRIVIUM_DEC_PREFETCH_EN
                    // A byte emitted from the buffer may still be waiting on the consumer here
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                    if (r_in_ready && in_valid) begin
                        r_out_data  <= in_data ^ r_ks;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_bcnt      <= '0;
                        r_state     <= GEN;
                    end
`else
                    if (r_in_ready && in_valid) begin
                        r_din      <= in_data;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_bcnt     <= '0;
                        r_state    <= GEN;
                    end
`endif
                end
                GEN: begin
                    r_s    <= w_s_next;
                    r_ks   <= {w_z, r_ks[7:1]};
                    r_bcnt <= r_bcnt + 3'd1;
`ifdef TRIVIUM_DEC_PREFETCH_EN
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    if (r_bcnt == 3'd7) begin
                        r_state     <= READY;
                        r_busy      <= 1'b0;
                        r_init_done <= 1'b1;
                        r_in_ready  <= !r_out_valid || out_ready;
                    end
`else
                    if (r_bcnt == 3'd7) begin
                        r_state     <= OUT;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_din ^ {w_z, r_ks[7:1]};
                    end
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= READY;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign init_done = r_init_done;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_trivium_stream_decrypt.sv
// Self-checking bench for trivium_stream_decrypt against a bit-array Trivium reference model.
module tb_trivium_stream_decrypt;
`ifdef TRIVIUM_DEC_PREFETCH_EN
    localparam int INIT_CYC = 1160;
    localparam int LAT      = 0;
    localparam int RATE     = 9;
`else
    localparam int INIT_CYC = 1152;
    localparam int LAT      = 8;
    localparam int RATE     = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [79:0] key = '0;
    logic [79:0] iv = '0;
    logic        busy, init_done, in_ready, out_valid;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data = '0;
    logic [7:0]  out_data;

    int n_checks = 0;
    int n_err    = 0;

    trivium_stream_decrypt dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv),
        .busy(busy), .init_done(init_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: state bits s1..s288 with 1-based indexing, straight from the cipher definition
    bit         ms [1:288];
    logic [7:0] ks_ref [0:63];

    task automatic m_round(output bit z);
        bit t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
        ms[178] = t2;
        for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
        ms[1] = t3;
    endtask

    task automatic m_session(input logic [79:0] k, input logic [79:0] v);
        bit z;
        logic [7:0] b;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ms[i+1]  = k[i];
            ms[i+94] = v[i];
        end
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
        for (int r = 0; r < 1152; r++) m_round(z);
        for (int n = 0; n < 64; n++) begin
            for (int j = 0; j < 8; j++) begin
                m_round(z);
                b[j] = z;
            end
            ks_ref[n] = b;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [79:0] k, input logic [79:0] v);
        start = 1'b1; key = k; iv = v;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        chk("init_done_low", 32'(init_done), 0);
        while (busy && n < 3000) begin
            n++;
            tick();
        end
        chk("init_cycles", n, INIT_CYC);
        chk("init_done", 32'(init_done), 1);
        chk("init_in_ready", 32'(in_ready), 1);
    endtask

    task automatic xfer(input logic [7:0] ct, input int stall, output logic [7:0] pt);
        int n, lat;
        in_valid = 1'b1; in_data = ct; n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0; in_data = 8'($urandom);
        chk("accept_drops_ready", 32'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("latency", lat, LAT);
        repeat (stall) tick();
        pt = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    localparam logic [79:0] K1 = 80'h0123456789ABCDEF0123;
    logic [7:0]  kbuf [0:15];
    logic [7:0]  pt, hold, ct, ev;
    logic [79:0] kr, vr;
    logic [7:0]  q[$];
    int bad, n, last, kp;

    initial begin
        // Reset held with in_valid asserted
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_busy", 32'(busy), 0);
        bad = 0;
        repeat (10) begin
            tick();
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        chk("idle_no_accept", bad, 0);
        in_valid = 1'b0;

        // Init timing with all-zero key/iv
        do_start(80'd0, 80'd0);
        chk("start_busy", 32'(busy), 1);
        wait_init();

        // Keystream against the model
        m_session(K1, 80'd0);
        do_start(K1, 80'd0);
        wait_init();
        for (int i = 0; i < 16; i++) begin
            xfer(8'h00, 0, pt);
            chk("ks_byte", 32'(pt), 32'(ks_ref[i]));
            kbuf[i] = pt;
        end

        // Round trip: feeding the keystream back yields zeros
        do_start(K1, 80'd0);
        wait_init();
        for (int i = 0; i < 16; i++) begin
            xfer(kbuf[i], i % 3, pt);
            chk("roundtrip", 32'(pt), 0);
        end

        // Backpressure: 50 stalled cycles with in_valid held
        in_valid = 1'b1; in_data = 8'h3C; n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        in_data = 8'h77; n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        hold = out_data;
        chk("bp_data", 32'(hold), 32'(8'h3C ^ ks_ref[16]));
        bad = 0;
        repeat (50) begin
            tick();
            if (out_data !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        chk("bp_stable", bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        xfer(8'h77, 0, pt);
        chk("bp_next", 32'(pt), 32'(8'h77 ^ ks_ref[17]));

        // Restart three cycles after an accept
        in_valid = 1'b1; in_data = 8'h00; n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        do_start(K1, 80'd0);
        chk("abort_out_valid", 32'(out_valid), 0);
        wait_init();
        chk("abort_no_out", 32'(out_valid), 0);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, 0, pt);
            chk("abort_ks", 32'(pt), 32'(ks_ref[i]));
        end

        // Random key/iv/ciphertext with random consumer stalls
        kr = {16'($urandom), $urandom, $urandom};
        vr = {16'($urandom), $urandom, $urandom};
        m_session(kr, vr);
        do_start(kr, vr);
        wait_init();
        for (int i = 0; i < 8; i++) begin
            ct = 8'($urandom);
            xfer(ct, int'($urandom_range(0, 4)), pt);
            chk("rand_pt", 32'(pt), 32'(ct ^ ks_ref[i]));
        end

        // Sustained streaming with both handshakes held open
        kp = 8; last = -1; q.delete();
        in_valid = 1'b1; out_ready = 1'b1; in_data = 8'($urandom);
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                if (q.size() == 0) chk("stream_extra", 32'(out_valid), 0);
                else begin
                    ev = q.pop_front();
                    chk("stream_data", 32'(out_data), 32'(ev));
                end
            end
            if (in_ready) begin
                q.push_back(in_data ^ ks_ref[kp]);
                kp++;
                if (last >= 0) chk("rate_gap", c - last, RATE);
                last = c;
            end
            tick();
            in_data = 8'($urandom);
        end
        in_valid = 1'b0; n = 0;
        while (q.size() > 0 && n < 40) begin
            if (out_valid) begin
                ev = q.pop_front();
                chk("stream_drain", 32'(out_data), 32'(ev));
            end
            tick();
            n++;
        end
        chk("stream_drained", q.size(), 0);
        out_ready = 1'b0;

        // Reset mid-initialisation
        do_start(kr, vr);
        repeat (100) tick();
        in_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_init_done", 32'(init_done), 0);
        bad = 0;
        repeat (20) begin
            tick();
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("midrst_idle", bad, 0);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
